// File: rtl/render_pkg.sv
// render_pkg: shared widths, constants and types for the vertex homogenizer
package render_pkg;
    localparam int FP_W = 16;
    localparam logic signed [FP_W-1:0] ONE_FP = 16'sh0100;
    localparam int MS_VALID = 3;
    localparam int MS_CNT_HI = 2;
    localparam int MS_CNT_LO = 0;
    typedef logic bank_t;
    typedef logic signed [FP_W-1:0] fp_t;
    typedef struct packed {
        fp_t w;
        fp_t z;
        fp_t y;
        fp_t x;
    } vec_t;
    typedef vec_t [3:0] mat_t;
endpackage

// File: rtl/vertex_homogenizer_if.sv
// vertex_homogenizer_if: vertex stream in, homogeneous matrix out to normalization
interface vertex_homogenizer_if;
    import render_pkg::*;
    logic in_valid;
    logic in_ready;
    fp_t in_X, in_Y, in_Z;
    logic in_last;
    logic mat_ack;
    fp_t d11, d12, d13, d14;
    fp_t d21, d22, d23, d24;
    fp_t d31, d32, d33, d34;
    fp_t d41, d42, d43, d44;
    logic [3:0] matrix_state;
    modport master (
        output in_valid, in_X, in_Y, in_Z, in_last, mat_ack,
        input in_ready, matrix_state,
        input d11, d12, d13, d14, d21, d22, d23, d24,
        input d31, d32, d33, d34, d41, d42, d43, d44
    );
    modport slave (
        input in_valid, in_X, in_Y, in_Z, in_last, mat_ack,
        output in_ready, matrix_state,
        output d11, d12, d13, d14, d21, d22, d23, d24,
        output d31, d32, d33, d34, d41, d42, d43, d44
    );
endinterface

// File: rtl/matrix_bank.sv
// matrix_bank: one 4-column vertex store that closes on its 4th or last vertex
module matrix_bank
    import render_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       we,
    input  logic [1:0] col,
    input  vec_t       v,
    input  logic       last,
    output logic       full,
    output logic [2:0] count,
    output mat_t       m
);
    // write a column; the closing write records the count, clear zeroes every column
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m     <= '0;
            full  <= 1'b0;
            count <= '0;
        end else if (clr) begin
            m     <= '0;
            full  <= 1'b0;
            count <= '0;
        end else if (we) begin
            m[col] <= v;
            if (col == 2'd3 || last) begin
                full  <= 1'b1;
                count <= {1'b0, col} + 3'd1;
            end
        end
    end
endmodule

// File: rtl/vertex_homogenizer.sv
// vertex_homogenizer: packs vertices into ping-pong 4x4 homogeneous matrices
module vertex_homogenizer
    import render_pkg::*;
#(
    parameter logic signed [FP_W-1:0] ONE_FP = render_pkg::ONE_FP
) (
    input logic                 CLK,
    input logic                 rst,
    vertex_homogenizer_if.slave bus
);
    bank_t      fill, pres;
    logic [1:0] wr_col;
    logic       valid;
    logic [2:0] cnt;
    mat_t       dm;
    logic [1:0] full;
    logic [2:0] bcount [2];
    mat_t       bm [2];
    logic       acc, done, ovl_full;
    logic [2:0] ovl_cnt;
    mat_t       ovl;
    vec_t       v;

    assign bus.in_ready = rst && !full[fill];
    assign acc  = bus.in_valid && bus.in_ready;
    assign done = acc && (wr_col == 2'd3 || bus.in_last);
    assign v    = '{w: ONE_FP, z: bus.in_Z, y: bus.in_Y, x: bus.in_X};

    for (genvar i = 0; i < 2; i++) begin : g_bank
        matrix_bank u_bank (
            .clk   (CLK),
            .rst   (rst),
            .clr   (valid && bus.mat_ack && pres == bank_t'(i)),
            .we    (acc && fill == bank_t'(i)),
            .col   (wr_col),
            .v     (v),
            .last  (bus.in_last),
            .full  (full[i]),
            .count (bcount[i]),
            .m     (bm[i])
        );
    end

    // the other bank as it will look after this edge, so an ack can hand over without a gap
    always_comb begin
        ovl      = bm[~pres];
        ovl_cnt  = bcount[~pres];
        ovl_full = full[~pres];
        if (done && fill != pres) begin
            ovl[wr_col] = v;
            ovl_cnt     = {1'b0, wr_col} + 3'd1;
            ovl_full    = 1'b1;
        end
    end

    // fill side: advance the write column and swap banks when a primitive closes
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            fill   <= '0;
            wr_col <= '0;
        end else if (acc) begin
            wr_col <= done ? 2'd0 : wr_col + 2'd1;
            if (done) fill <= ~fill;
        end
    end

    // present side: show the oldest full bank, hold it until acked, then move on
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            dm    <= '0;
            valid <= 1'b0;
            cnt   <= '0;
            pres  <= '0;
        end else if (!valid) begin
            if (full[pres]) begin
                dm    <= bm[pres];
                cnt   <= bcount[pres];
                valid <= 1'b1;
            end
        end else if (bus.mat_ack) begin
            pres  <= ~pres;
            valid <= ovl_full;
            cnt   <= ovl_full ? ovl_cnt : 3'd0;
            if (ovl_full) dm <= ovl;
        end
    end

    assign bus.matrix_state[MS_VALID] = valid;
    assign bus.matrix_state[MS_CNT_HI:MS_CNT_LO] = cnt;
    assign bus.d11 = dm[0].x, bus.d12 = dm[1].x, bus.d13 = dm[2].x, bus.d14 = dm[3].x;
    assign bus.d21 = dm[0].y, bus.d22 = dm[1].y, bus.d23 = dm[2].y, bus.d24 = dm[3].y;
    assign bus.d31 = dm[0].z, bus.d32 = dm[1].z, bus.d33 = dm[2].z, bus.d34 = dm[3].z;
    assign bus.d41 = dm[0].w, bus.d42 = dm[1].w, bus.d43 = dm[2].w, bus.d44 = dm[3].w;
endmodule

// File: tb/tb_vertex_homogenizer.sv
// tb_vertex_homogenizer: directed scenarios plus random traffic against a queue model
module tb_vertex_homogenizer;
    import render_pkg::*;

    typedef struct {
        logic [255:0] m;
        int           cnt;
    } mrec_t;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    mrec_t pend[$];
    logic [15:0] cur [4][4];
    int col = 0;
    bit shown = 0;
    logic [255:0] last_d = '0;
    logic [255:0] d_flat;

    always #5 CLK = ~CLK;

    vertex_homogenizer_if bus();
    vertex_homogenizer dut (.CLK(CLK), .rst(rst), .bus(bus));

    assign d_flat = {bus.d11, bus.d12, bus.d13, bus.d14, bus.d21, bus.d22, bus.d23, bus.d24,
                     bus.d31, bus.d32, bus.d33, bus.d34, bus.d41, bus.d42, bus.d43, bus.d44};

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] pack_cur();
        logic [255:0] f = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                f = {f[239:0], cur[r][c]};
        return f;
    endfunction

    function automatic logic [3:0] exp_ms();
        return shown ? {1'b1, 3'(pend[0].cnt)} : 4'h0;
    endfunction

    task automatic model_reset();
        pend.delete();
        shown = 0;
        last_d = '0;
        col = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                cur[r][c] = '0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] x, y, z, input logic l, input logic a);
        bit fin = 0;
        mrec_t rec;
        if (v && pend.size() < 2) begin
            cur[0][col] = x;
            cur[1][col] = y;
            cur[2][col] = z;
            cur[3][col] = 16'h0100;
            if (col == 3 || l) begin
                rec.m = pack_cur();
                rec.cnt = col + 1;
                fin = 1;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        cur[r][c] = '0;
                col = 0;
            end else col++;
        end
        if (shown && a) begin
            void'(pend.pop_front());
            if (fin) pend.push_back(rec);
            shown = pend.size() > 0;
        end else begin
            if (!shown) shown = pend.size() > 0;
            if (fin) pend.push_back(rec);
        end
        if (shown) last_d = pend[0].m;
    endtask

    task automatic tick(input logic v, input logic [15:0] x, y, z, input logic l, input logic a);
        bus.in_valid = v;
        bus.in_X = x;
        bus.in_Y = y;
        bus.in_Z = z;
        bus.in_last = l;
        bus.mat_ack = a;
        #1 check("in_ready", bus.in_ready, pend.size() < 2);
        @(posedge CLK);
        model_step(v, x, y, z, l, a);
        @(negedge CLK);
        check("matrix_state", bus.matrix_state, exp_ms());
        check("d_matrix", d_flat, last_d);
    endtask

    task automatic vtx(input int n, input logic l, input logic a);
        tick(1'b1, 16'(3 * n - 2), 16'(3 * n - 1), 16'(3 * n), l, a);
    endtask

    task automatic idle(input logic a);
        tick(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, a);
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_X = 0;
        bus.in_Y = 0;
        bus.in_Z = 0;
        bus.in_last = 0;
        bus.mat_ack = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        check("reset_state", bus.matrix_state, 4'h0);
        check("reset_d", d_flat, 256'h0);
        check("reset_ready", bus.in_ready, 1'b0);
        rst = 1'b1;

        for (int n = 1; n <= 4; n++) vtx(n, 1'b0, 1'b0);
        idle(1'b0);
        check("s1_state", bus.matrix_state, 4'hC);
        check("s1_d11", bus.d11, 16'd1);
        check("s1_d34", bus.d34, 16'd12);
        check("s1_w_row", {bus.d41, bus.d42, bus.d43, bus.d44}, {4{16'h0100}});
        idle(1'b1);
        check("ack_idle_state", bus.matrix_state, 4'h0);
        check("idle_hold_d11", bus.d11, 16'd1);

        vtx(1, 1'b0, 1'b0);
        vtx(2, 1'b0, 1'b0);
        vtx(3, 1'b1, 1'b0);
        idle(1'b0);
        check("s2_state", bus.matrix_state, 4'hB);
        check("s2_col4_zero", {bus.d14, bus.d24, bus.d34, bus.d44}, 64'h0);
        idle(1'b1);

        for (int n = 1; n <= 12; n++) vtx(n, 1'b0, 1'b0);
        check("s3_ready_low", bus.in_ready, 1'b0);
        check("s3_state", bus.matrix_state, 4'hC);
        check("s3_hold_d11", bus.d11, 16'd1);
        idle(1'b1);
        check("s3_second_d11", bus.d11, 16'd13);
        check("s3_second_state", bus.matrix_state, 4'hC);

        vtx(30, 1'b0, 1'b0);
        vtx(31, 1'b0, 1'b0);
        vtx(32, 1'b0, 1'b0);
        vtx(33, 1'b0, 1'b1);
        check("s4_no_gap", bus.matrix_state, 4'hC);
        check("s4_d11", bus.d11, 16'd88);
        check("s4_d14", bus.d14, 16'd97);
        idle(1'b1);

        for (int n = 20; n <= 23; n++) vtx(n, 1'b0, 1'b0);
        idle(1'b0);
        vtx(24, 1'b0, 1'b0);
        vtx(25, 1'b0, 1'b0);
        bus.in_valid = 0;
        bus.mat_ack = 0;
        #2 rst = 1'b0;
        #1;
        check("s5_async_state", bus.matrix_state, 4'h0);
        check("s5_async_d", d_flat, 256'h0);
        check("s5_async_ready", bus.in_ready, 1'b0);
        model_reset();
        @(negedge CLK);
        rst = 1'b1;
        for (int n = 40; n <= 43; n++) vtx(n, 1'b0, 1'b0);
        idle(1'b0);
        check("s5_state", bus.matrix_state, 4'hC);
        check("s5_d11", bus.d11, 16'd118);
        check("s5_d34", bus.d34, 16'd129);
        idle(1'b1);

        for (int k = 0; k < 400; k++)
            tick($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vertex_homogenizer.md
VERTEX_HOMOGENIZER -- requirements
Module: vertex_homogenizer

Interface
REQ-001 Parameter ONE_FP, default 16'sh0100, fixed-point 1.0 (Q8.8) written into the W row.
REQ-002 The clock port SHALL be CLK, input, 1 bit, the single clock; all state on rising edge.
REQ-003 The reset port SHALL be rst, input, 1 bit, asynchronous, active-low.
REQ-004 in_valid  input  1  vertex on in_X/in_Y/in_Z is offered.
REQ-005 in_ready  output  1  block can accept a vertex this cycle.
REQ-006 in_X, in_Y, in_Z  input  16 signed  vertex coordinates, Q8.8.
REQ-007 in_last  input  1  accompanying vertex ends the current primitive.
REQ-008 mat_ack  input  1  downstream normalization has consumed the presented matrix.
REQ-009 d11..d44  output  16 signed each, registered  4x4 homogeneous matrix; column j is vertex j: d1j=X, d2j=Y, d3j=Z, d4j=W.
REQ-010 matrix_state  output  4, registered  bit3 = matrix valid; bits2:0 = vertex count 1..4.

Function
REQ-011 Two internal banks (ping-pong) SHALL each hold one 4-column matrix plus a full flag and count.
REQ-012 in_ready SHALL be 1 iff the fill bank is not full; derived from registered flags only, with no combinational path from mat_ack.
REQ-013 A vertex SHALL be accepted only when in_valid and in_ready are both 1 on a rising edge.
REQ-014 An accepted vertex SHALL be written to column wr_col of the fill bank, with W = ONE_FP; wr_col then increments.
REQ-015 The bank SHALL complete on acceptance with wr_col==3 or in_last=1; count = wr_col+1; full set; fill pointer toggles; wr_col returns to 0.
REQ-016 Columns not written before in_last SHALL read as all zero, including W=0.
REQ-017 Presentation: when matrix_state[3]=0 and a full bank exists, the oldest full bank SHALL be copied to d11..d44 and matrix_state = {1,count} on the next edge.
REQ-018 A vertex completing a bank when the output is idle SHALL produce a valid matrix one cycle after the accepting edge.
REQ-019 Holding: while matrix_state[3]=1 and mat_ack=0, the d outputs and matrix_state SHALL not change.
REQ-020 On mat_ack=1 with matrix_state[3]=1, the presented bank SHALL be freed, and on the next edge the output shows the other full bank if one exists, else matrix_state=0.
REQ-021 When matrix_state=0, d values SHALL hold their last contents.
REQ-022 mat_ack while matrix_state[3]=0 SHALL be ignored.
REQ-023 On simultaneous mat_ack and completion of the other bank, the new matrix SHALL be presented on the next edge with no idle cycle.
REQ-024 When both banks are full, in_ready=0; in_ready SHALL return to 1 the cycle after the acked bank is freed.
REQ-025 Matrices SHALL be presented in completion order; none dropped, none duplicated.
REQ-026 Coordinates SHALL pass through unmodified; no arithmetic on X/Y/Z.

Reset
REQ-027 While rst=0: d11..d44=0, matrix_state=0, in_ready=0, both banks empty, wr_col=0, fill/present pointers = bank 0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 A reset mid-primitive SHALL discard the partial and all full banks; no stale matrix is presented afterwards.

Structure
REQ-030 Package render_pkg SHALL hold FP_W=16, ONE_FP, the matrix_state field constants (MS_VALID=3, count field 2:0) and the bank-index type.
REQ-031 Sub-module matrix_bank (4-column store, write-column port, full/count flags, clear) SHALL be instantiated twice.
REQ-032 The outputs SHALL connect directly to the existing normalization stage's d11..d44 and matrix_state inputs.

Verification
REQ-033 Scenario 1: 4 vertices (1,2,3),(4,5,6),(7,8,9),(10,11,12), back-to-back -> one cycle after the 4th accept, matrix_state=4'hC, d11=1, d34=12, d41..d44=16'h0100.
REQ-034 Scenario 2: 3 vertices, the 3rd with in_last -> matrix_state=4'hB; d14=d24=d34=d44=0.
REQ-035 Scenario 3: 12 vertices, mat_ack never asserted -> 1st matrix held stable, 2nd bank fills, in_ready=0 after vertex 8, vertex 9 not accepted.
REQ-036 Scenario 4: mat_ack asserted in the same cycle the 2nd bank completes -> 2nd matrix presented on the next edge with no matrix_state=0 gap.
REQ-037 Scenario 5: rst pulsed low after 2 vertices and while one matrix is presented -> all outputs 0 immediately (asynchronous); after release the next 4 vertices yield a matrix holding only the new data.
